// File: rtl/dual_port_mem_responder.sv
// Unified instruction/data word array with a 16-byte MMIO window.
// Define DUAL_PORT_MEM_RESPONDER_MMIO_EN to build the MMIO window, cycle counter, done and tohost.
module dual_port_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] im_addr,
    output logic [31:0] im_rdata,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_web,
    output logic [31:0] dm_rdata,
    output logic        done,
    output logic [31:0] tohost,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
`ifdef DUAL_PORT_MEM_RESPONDER_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  web
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (web[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] im_idx;
    logic [AW-1:0] dm_idx;
    logic          im_arr;
    logic          dm_arr;
    logic          im_mmio;
    logic          dm_mmio;
    logic          im_oor;
    logic          dm_oor;
    logic          dm_we;
    logic [31:0]   mmio_rdata;

    assign im_idx  = im_addr[AW+1:2];
    assign dm_idx  = dm_addr[AW+1:2];
    assign im_arr  = {1'b0, im_addr} < LIMIT;
    assign dm_arr  = {1'b0, dm_addr} < LIMIT;
    // Array decode wins should the window ever overlap the array.
    assign im_mmio = !im_arr && (im_addr[31:4] == MMIO_BASE[31:4]);
    assign dm_mmio = !dm_arr && (dm_addr[31:4] == MMIO_BASE[31:4]);
    assign im_oor  = !im_arr && !(MMIO_EN && im_mmio);
    assign dm_oor  = !dm_arr && !(MMIO_EN && dm_mmio);
    assign dm_we   = |dm_web;

    assign im_rdata = im_arr ? mem[im_idx] : 32'h0;

    always_comb begin
        dm_rdata = 32'h0;
        if (dm_arr)
            dm_rdata = mem[dm_idx];
        else if (MMIO_EN && dm_mmio)
            dm_rdata = mmio_rdata;
    end

    // Array contents survive reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && dm_we && dm_arr)
            mem[dm_idx] <= merge(mem[dm_idx], dm_wdata, dm_web);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (im_oor || (dm_oor && dm_we))
            err <= 1'b1;
    end

`ifdef DUAL_PORT_MEM_RESPONDER_MMIO_EN
    logic [63:0] cycle;
    logic [31:0] scratch;
    logic [31:0] tohost_q;
    logic        done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle    <= 64'h0;
            scratch  <= 32'h0;
            tohost_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            cycle <= cycle + 64'h1;
            if (dm_we && dm_mmio) begin
                unique case (dm_addr[3:2])
                    2'd2: begin
                        tohost_q <= merge(tohost_q, dm_wdata, dm_web);
                        done_q   <= 1'b1;
                    end
                    2'd3:    scratch <= merge(scratch, dm_wdata, dm_web);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mmio_rdata = 32'h0;
        unique case (dm_addr[3:2])
            2'd0: mmio_rdata = cycle[31:0];
            2'd1: mmio_rdata = cycle[63:32];
            2'd2: mmio_rdata = tohost_q;
            2'd3: mmio_rdata = scratch;
        endcase
    end

    assign done   = done_q;
    assign tohost = tohost_q;
`else
    assign mmio_rdata = 32'h0;
    assign done       = 1'b0;
    assign tohost     = 32'h0;
`endif

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Randomised bench for dual_port_mem_responder against a word/byte reference model.
// Honours DUAL_PORT_MEM_RESPONDER_MMIO_EN the same way the design does.
module tb_dual_port_mem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] im_addr = 32'h0;
    logic [31:0] im_rdata;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic [3:0]  dm_web = 4'h0;
    logic [31:0] dm_rdata;
    logic        done;
    logic [31:0] tohost;
    logic        err;

    always #5 clk = ~clk;

    dual_port_mem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .im_addr (im_addr),
        .im_rdata(im_rdata),
        .dm_addr (dm_addr),
        .dm_wdata(dm_wdata),
        .dm_web  (dm_web),
        .dm_rdata(dm_rdata),
        .done    (done),
        .tohost  (tohost),
        .err     (err)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [64];
    logic [63:0] ref_cyc = 64'h0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] web);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (web[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One clock edge; the model counter ticks only for edges outside reset.
    task automatic step();
        @(posedge clk);
        if (!rst) ref_cyc = ref_cyc + 64'h1;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] web);
        dm_addr  = a;
        dm_wdata = d;
        dm_web   = web;
        step();
        dm_web = 4'h0;
        #1;
    endtask

    initial begin
        int          w;
        int          r;
        logic [3:0]  web;
        logic [31:0] v;

        step();
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tohost", tohost, 0);
        step();
        rst     = 1'b0;
        ref_cyc = 64'h0;

`ifdef DUAL_PORT_MEM_RESPONDER_MMIO_EN
        repeat (5) step();
        dm_addr = MMIO;
        #1;
        check("cycle_lo_5", dm_rdata, ref_cyc[31:0]);
        dm_addr = MMIO + 4;
        #1;
        check("cycle_hi", dm_rdata, ref_cyc[63:32]);
        check("done_pre", done, 0);
        wr(MMIO + 8, 32'h1, 4'hF);
        check("done_set", done, 1);
        check("tohost_1", tohost, 32'h1);
        wr(MMIO + 12, 32'h1122_3344, 4'hF);
        wr(MMIO + 12, 32'hAABB_CCDD, 4'b0101);
        dm_addr = MMIO + 12;
        #1;
        check("scratch_mask", dm_rdata, 32'h1122_3344 & 32'hFF00_FF00
                                        | 32'h00BB_00DD);
        wr(MMIO, 32'hFFFF_FFFF, 4'hF);
        dm_addr = MMIO;
        #1;
        check("cycle_ro", dm_rdata, ref_cyc[31:0]);
        check("cycle_wr_noerr", err, 0);
        wr(MMIO + 8, 32'h0000_5500, 4'b0010);
        check("tohost_merge", tohost, 32'h0000_5501);
        check("done_sticky", done, 1);
        dm_addr = MMIO + 8;
        im_addr = MMIO + 8;
        #1;
        check("tohost_rd", dm_rdata, 32'h0000_5501);
        check("im_mmio_zero", im_rdata, 0);
        step();
        check("im_mmio_noerr", err, 0);
        im_addr = 32'h0;
`endif

        wr(32'h100, 32'hDEAD_BEEF, 4'hF);
        dm_addr = 32'h100;
        im_addr = 32'h100;
        #1;
        check("dm_beef", dm_rdata, 32'hDEAD_BEEF);
        check("im_beef", im_rdata, 32'hDEAD_BEEF);
        dm_wdata = 32'h0000_00AA;
        dm_web   = 4'b0001;
        #1;
        check("dm_old_same", dm_rdata, 32'hDEAD_BEEF);
        check("im_old_same", im_rdata, 32'hDEAD_BEEF);
        step();
        dm_web = 4'h0;
        #1;
        check("dm_lane0", dm_rdata, 32'hDEAD_BEAA);
        check("im_lane0", im_rdata, 32'hDEAD_BEAA);

        wr(32'h0000_FFFC, 32'h5A5A_A5A5, 4'hF);
        im_addr = 32'h0000_FFFF;
        #1;
        check("top_word", im_rdata, 32'h5A5A_A5A5);

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            wr(32'(i) << 2, ref_mem[i], 4'hF);
        end
        for (int k = 0; k < 300; k++) begin
            w   = $urandom_range(0, 63);
            r   = $urandom_range(0, 63);
            web = 4'($urandom);
            dm_addr  = (32'(w) << 2) | 32'($urandom_range(0, 3));
            im_addr  = (32'(r) << 2) | 32'($urandom_range(0, 3));
            dm_wdata = $urandom;
            dm_web   = web;
            #1;
            check("rnd_dm", dm_rdata, ref_mem[w]);
            check("rnd_im", im_rdata, ref_mem[r]);
            step();
            ref_mem[w] = lanes(ref_mem[w], dm_wdata, web);
        end
        dm_web = 4'h0;
        #1;
        check("rnd_noerr", err, 0);

        wr(32'h200, 32'h1234_5678, 4'hF);
        dm_addr  = 32'h200;
        dm_wdata = 32'hCAFE_F00D;
        dm_web   = 4'hF;
        #2;
        rst = 1'b1;
        ref_cyc = 64'h0;
        #1;
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_tohost", tohost, 0);
`ifdef DUAL_PORT_MEM_RESPONDER_MMIO_EN
        dm_addr = MMIO;
        #1;
        check("arst_cycle", dm_rdata, 0);
        dm_addr = 32'h200;
`endif
        step();
        step();
        rst    = 1'b0;
        dm_web = 4'h0;
        #1;
        check("arst_word_kept", dm_rdata, 32'h1234_5678);
`ifdef DUAL_PORT_MEM_RESPONDER_MMIO_EN
        repeat (3) step();
        dm_addr = MMIO;
        #1;
        check("cycle_restart", dm_rdata, ref_cyc[31:0]);
`else
        wr(MMIO + 8, 32'h1, 4'hF);
        check("nommio_done", done, 0);
        check("nommio_tohost", tohost, 0);
        check("nommio_err", err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
`endif

        im_addr  = 32'h0;
        dm_addr  = 32'h0001_0000;
        dm_wdata = 32'hFFFF_FFFF;
        dm_web   = 4'hF;
        #1;
        check("oor_rd_zero", dm_rdata, 0);
        check("oor_err_pre", err, 0);
        step();
        dm_web = 4'h0;
        #1;
        check("oor_err", err, 1);
        repeat (10) step();
        check("oor_err_sticky", err, 1);
        check("oor_no_alias", im_rdata, ref_mem[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_responder.md
DUAL_PORT_MEM_RESPONDER -- requirements
Module: dual_port_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16384, meaning number of 32-bit words in the unified array (64 KiB).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, meaning base address of the 16-byte MMIO window.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port im_addr, input, 32, instruction fetch byte address.
REQ-006 SHALL have port im_rdata, output, 32, instruction word read data.
REQ-007 SHALL have port dm_addr, input, 32, data byte address.
REQ-008 SHALL have port dm_wdata, input, 32, data write data, lane-aligned.
REQ-009 SHALL have port dm_web, input, 4, per-byte write enable, active-high; bit i writes byte lane i (bits 8i+7:8i); 4'b0000 = no write.
REQ-010 SHALL have port dm_rdata, output, 32, data read word.
REQ-011 SHALL have port done, output, 1, test-complete flag.
REQ-012 SHALL have port tohost, output, 32, last value written to TOHOST.
REQ-013 SHALL have port err, output, 1, sticky out-of-range access flag.

Function
REQ-014 SHALL serve both read ports combinationally (zero-cycle latency) from the same array: word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
REQ-015 SHALL perform array writes on the rising clk edge, updating only lanes with dm_web bit set; unselected lanes keep prior contents.
REQ-016 SHALL return pre-write (old) data on both read ports during the cycle in which a write to the same word is issued; new data is visible the following cycle.
REQ-017 SHALL decode address as in-array when addr < 4*DEPTH_WORDS, MMIO when addr[31:4] == MMIO_BASE[31:4], otherwise out-of-range.
REQ-018 SHALL return 32'h0 for out-of-range reads, ignore out-of-range writes, and set err on the next edge for any out-of-range im_addr, or for an out-of-range dm_addr when dm_web != 0.
REQ-019 SHALL return 32'h0 on im_rdata for MMIO addresses; instruction fetch never observes MMIO registers.
REQ-020 SHALL keep a free-running 64-bit cycle counter, +1 every clk edge out of reset, wrapping 2^64-1 -> 0.
REQ-021 SHALL map MMIO offsets: 0x0 CYCLE_LO (RO, counter[31:0]); 0x4 CYCLE_HI (RO, counter[63:32]); 0x8 TOHOST (RW); 0xC SCRATCH (RW, byte-maskable).
REQ-022 SHALL ignore writes to CYCLE_LO/CYCLE_HI without setting err.
REQ-023 SHALL, on any write to TOHOST with dm_web != 0, latch the lane-merged value into tohost and set done on that edge; done is sticky until reset.
REQ-024 SHALL give later writes to TOHOST after done priority: tohost updates, done stays 1.
REQ-025 SHALL expose counter values as of the current cycle (pre-increment) on dm_rdata.

Reset
REQ-026 SHALL, while rst is high, force counter=0, tohost=0, SCRATCH=0, done=0, err=0, and block all array and MMIO writes.
REQ-027 SHALL NOT reset array contents; reads remain combinational during reset.
REQ-028 SHALL restart the counter at 0 and resume writes on the first clk edge after rst deasserts; a mid-operation reset discards the in-flight write.

Configuration
REQ-029 SHALL, when macro DUAL_PORT_MEM_RESPONDER_MMIO_EN is defined, implement the MMIO window, counter, done, tohost per REQ-020..REQ-025.
REQ-030 SHALL, when DUAL_PORT_MEM_RESPONDER_MMIO_EN is undefined, omit MMIO logic, tie done=0 and tohost=0, and treat MMIO addresses as out-of-range per REQ-018.

Verification
REQ-031 SHALL cover: dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_web=4'b1111, then dm_web=0 -> next cycle dm_rdata=0xDEADBEEF and im_addr=0x100 gives im_rdata=0xDEADBEEF.
REQ-032 SHALL cover: word 0x100=0xDEADBEEF, write dm_wdata=0x000000AA, dm_web=4'b0001 -> same cycle dm_rdata=0xDEADBEEF, next cycle 0xDEADBEAA.
REQ-033 SHALL cover: dm_addr=0x0001_0000 (DEPTH_WORDS=16384), dm_web=4'b1111 -> dm_rdata=0, array unchanged, err=1 after edge and stays 1 through 10 idle cycles.
REQ-034 SHALL cover (MMIO_EN): rst released, read CYCLE_LO after 5 edges -> 5; write 0x1 to 0xFFFF_0008 -> next cycle done=1, tohost=0x1.
REQ-035 SHALL cover: rst asserted asynchronously mid-cycle with dm_web=4'b1111 pending -> done/err/tohost/counter=0 immediately, target word unchanged.
REQ-036 SHALL cover (MMIO_EN undefined): write to 0xFFFF_0008 -> done=0, tohost=0, err=1.
